req_encoder: RTL and testbench



---
 rtl/req_encoder_pkg.sv | 41 ++++
 rtl/req_encoder_prio.sv | 24 ++
 rtl/req_encoder.sv | 107 ++++++++++
 tb/tb_req_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/req_encoder_pkg.sv
// ============================================================================
// Module  : req_encoder_pkg
// Brief   : Shared types, widths and helpers for the request encoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package req_encoder_pkg;

    localparam int VEC_W  = 4;
    localparam int CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index of the highest set bit; an all-zero vector maps to code 0.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [VEC_W-1:0] v);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (v[i]) begin
                code = CODE_W'(i);
            end
        end
        return code;
    endfunction

    function automatic logic is_onehot(input logic [VEC_W-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < VEC_W; i++) begin
            cnt = cnt + (v[i] ? 1 : 0);
        end
        return (cnt == 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_encoder_prio.sv
// ============================================================================
// Module  : req_encoder_prio
// Brief   : Combinational highest-set-bit encoder with one-hot clear mask.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module req_encoder_prio
    import req_encoder_pkg::*;
(
    input  logic [VEC_W-1:0]  pend,
    output logic [CODE_W-1:0] code,
    output logic [VEC_W-1:0]  clear_mask
);

    logic [CODE_W-1:0] w_code;

    assign w_code     = prio_enc(pend);
    assign code       = w_code;
    assign clear_mask = (pend != '0) ? (VEC_W'(1) << w_code) : '0;

endmodule

`default_nettype wire

// File: rtl/req_encoder.sv
// ============================================================================
// Module  : req_encoder
// Brief   : Sequential 4-to-2 encoder; one code per set request bit, highest
//           index first. Define REQ_ENCODER_ERR_EN to add the err output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module req_encoder
    import req_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last
`ifdef REQ_ENCODER_ERR_EN
    ,
    output logic              err
`endif
);

    state_t            r_state;
    logic [VEC_W-1:0]  r_pend;
    logic              r_en;
    logic [CODE_W-1:0] w_code;
    logic [VEC_W-1:0]  w_clear;
    logic              w_last;
    logic              w_in_fire;
    logic              w_vec_zero;

    req_encoder_prio u_prio (
        .pend       (r_pend),
        .code       (w_code),
        .clear_mask (w_clear)
    );

    assign w_last     = is_onehot(r_pend);
    assign w_vec_zero = (in_vec == '0);

    // r_en keeps in_ready low until the first edge after reset release.
    assign in_ready  = r_en && ((r_state == IDLE) ||
                                ((r_state == EMIT) && out_ready && w_last));
    assign w_in_fire = in_valid && in_ready;

    assign out_valid = (r_state == EMIT);
    assign out_code  = w_code;
    assign out_last  = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_en    <= 1'b0;
        end else begin
            r_en <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_in_fire && !w_vec_zero) begin
                        r_pend  <= in_vec;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_last) begin
                            // Final beat: reload directly when a new vector arrives.
                            if (w_in_fire && !w_vec_zero) begin
                                r_pend <= in_vec;
                            end else begin
                                r_pend  <= '0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_pend <= r_pend & ~w_clear;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pend  <= '0;
                end
            endcase
        end
    end

`ifdef REQ_ENCODER_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_in_fire && w_vec_zero;
        end
    end

    assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_req_encoder.sv
// ============================================================================
// Module  : tb_req_encoder
// Brief   : Self-checking bench for req_encoder using a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_req_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_last;
`ifdef REQ_ENCODER_ERR_EN
    logic       err;
`endif

    int n_total;
    int n_bad;

    // Model: codes still owed to downstream, in emission order.
    int   m_q[$];
    logic m_en;
    logic m_err;

    req_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last)
`ifdef REQ_ENCODER_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic iv, input logic [3:0] vec,
                               input logic ordy, output logic accepted);
        logic exp_rdy;
        logic in_fire;
        logic out_fire;
        @(negedge clk);
        in_valid  = iv;
        in_vec    = vec;
        out_ready = ordy;
        #1;
        exp_rdy = m_en && ((m_q.size() == 0) || (ordy && m_q.size() == 1));
        check_val("in_ready", int'(in_ready), int'(exp_rdy));
        check_val("out_valid", int'(out_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("out_code", int'(out_code), m_q[0]);
            check_val("out_last", int'(out_last), int'(m_q.size() == 1));
        end
`ifdef REQ_ENCODER_ERR_EN
        check_val("err", int'(err), int'(m_err));
`endif
        in_fire  = iv && exp_rdy;
        out_fire = (m_q.size() != 0) && ordy;
        @(posedge clk);
        if (out_fire) begin
            void'(m_q.pop_front());
        end
        if (in_fire) begin
            for (int i = 3; i >= 0; i--) begin
                if (vec[i]) m_q.push_back(i);
            end
        end
        m_err    = in_fire && (vec == 4'd0);
        m_en     = 1'b1;
        accepted = in_fire;
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 4'd0, 1'b1, acc);
    endtask

    initial begin
        logic       acc;
        logic       hold_v;
        logic [3:0] hold_vec;
        logic       iv;
        logic [3:0] vec;

        n_total   = 0;
        n_bad     = 0;
        m_en      = 1'b0;
        m_err     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 4'd0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst out_valid", int'(out_valid), 0);
        check_val("rst in_ready", int'(in_ready), 0);
        check_val("rst out_code", int'(out_code), 0);
        check_val("rst out_last", int'(out_last), 0);
        rst_n = 1'b1;
        m_en  = 1'b1;

        // Single one-hot request
        drive_cycle(1'b1, 4'b0100, 1'b1, acc);
        idle_cycles(2);

        // Multi-hot with backpressure
        drive_cycle(1'b1, 4'b1011, 1'b1, acc);
        drive_cycle(1'b0, 4'd0, 1'b1, acc);
        drive_cycle(1'b0, 4'd0, 1'b0, acc);
        drive_cycle(1'b0, 4'd0, 1'b1, acc);
        drive_cycle(1'b0, 4'd0, 1'b0, acc);
        drive_cycle(1'b0, 4'd0, 1'b1, acc);
        idle_cycles(1);

        // Back-to-back vectors
        drive_cycle(1'b1, 4'b0001, 1'b1, acc);
        drive_cycle(1'b1, 4'b1000, 1'b1, acc);
        check_val("b2b accepted", int'(acc), 1);
        idle_cycles(2);

        // Zero vector
        drive_cycle(1'b1, 4'b0000, 1'b1, acc);
        idle_cycles(2);

        // Reset in the middle of an all-ones vector
        drive_cycle(1'b1, 4'b1111, 1'b1, acc);
        drive_cycle(1'b0, 4'd0, 1'b1, acc);
        drive_cycle(1'b0, 4'd0, 1'b1, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst out_valid", int'(out_valid), 0);
        check_val("midrst in_ready", int'(in_ready), 0);
        check_val("midrst out_last", int'(out_last), 0);
        check_val("midrst out_code", int'(out_code), 0);
        m_q.delete();
        m_err = 1'b0;
        m_en  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_en  = 1'b1;
        idle_cycles(3);

        // Randomized traffic; upstream holds an offered vector until taken
        hold_v   = 1'b0;
        hold_vec = 4'd0;
        for (int c = 0; c < 400; c++) begin
            if (hold_v) begin
                iv  = 1'b1;
                vec = hold_vec;
            end else begin
                iv  = ($urandom_range(0, 9) < 7);
                vec = 4'($urandom_range(0, 15));
            end
            drive_cycle(iv, vec, ($urandom_range(0, 3) != 0), acc);
            hold_v   = iv && !acc;
            hold_vec = vec;
        end
        idle_cycles(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
